// File: rtl/lcd_cmd_arbiter_if.sv
// lcd_cmd_arbiter_if: requester, LCD_CTRL and status signals of the command arbiter
// Ports (signals):
//   reqN_valid/reqN_cmd[2:0]/reqN_data[7:0]  requester N -> arbiter
//   reqN_ready/reqN_pop                      arbiter -> requester N
//   lcd_cmd[2:0]/lcd_cmd_valid/lcd_datain[7:0] arbiter -> LCD_CTRL
//   lcd_busy                                 LCD_CTRL -> arbiter
//   grant_id/done                            arbiter status
// Modports: slave = arbiter side, master = environment side.
interface lcd_cmd_arbiter_if;
    logic       req0_valid;
    logic [2:0] req0_cmd;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req0_pop;
    logic       req1_valid;
    logic [2:0] req1_cmd;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       req1_pop;
    logic [2:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic [7:0] lcd_datain;
    logic       lcd_busy;
    logic       grant_id;
    logic       done;

    modport slave (
        input  req0_valid, req0_cmd, req0_data, req1_valid, req1_cmd, req1_data, lcd_busy,
        output req0_ready, req0_pop, req1_ready, req1_pop, lcd_cmd, lcd_cmd_valid,
               lcd_datain, grant_id, done
    );

    modport master (
        output req0_valid, req0_cmd, req0_data, req1_valid, req1_cmd, req1_data, lcd_busy,
        input  req0_ready, req0_pop, req1_ready, req1_pop, lcd_cmd, lcd_cmd_valid,
               lcd_datain, grant_id, done
    );
endinterface

// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: round-robin scheduler of two command sources onto LCD_CTRL
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    lcd_cmd_arbiter_if.slave (requesters, LCD_CTRL cmd/data/busy, grant_id, done)
// Optional: define LCD_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties).
// Pixel contract: reqN_data is captured at each edge that starts a pop cycle; the
// pop cycle shows that pixel on lcd_datain, so the requester presents the next
// pixel while pop is high.
module lcd_cmd_arbiter #(
    parameter int IMG_N   = 108,
    parameter int BUSY_TO = 4,
    parameter int CNT_W   = 7
) (
    input logic             clk,
    input logic             reset,
    lcd_cmd_arbiter_if.slave bus
);
    // ISSUE is the single strobe cycle between the grant and LOAD/WAIT_HI
    typedef enum logic [2:0] {IDLE, ISSUE, LOAD, WAIT_HI, WAIT_LO, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [7:0]       datain_q, datain_d;
    logic             gnt_q, gnt_d, last_q, last_d, win;
    logic             valid_q, valid_d, done_q, done_d;
    logic             ready0_q, ready0_d, ready1_q, ready1_d, pop0_q, pop0_d, pop1_q, pop1_d;

    always_comb begin
`ifdef LCD_ARB_FIXED_PRIO_EN
        win = !bus.req0_valid;
`else
        win = (bus.req0_valid && bus.req1_valid) ? !last_q : bus.req1_valid;
`endif
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cmd_d   = cmd_q;
        case (state_q)
            IDLE: if (!bus.lcd_busy && (bus.req0_valid || bus.req1_valid)) begin
                state_d = ISSUE;
                gnt_d   = win;
                last_d  = win;
                cmd_d   = win ? bus.req1_cmd : bus.req0_cmd;
            end
            ISSUE: state_d = (cmd_q == 3'd0) ? LOAD : WAIT_HI;
            LOAD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(IMG_N - 1)) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.lcd_busy) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: if (!bus.lcd_busy) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // outputs are decoded from the next state so they appear with it, fully registered
        valid_d  = state_d == ISSUE;
        ready0_d = state_d == ISSUE && !gnt_d;
        ready1_d = state_d == ISSUE && gnt_d;
        pop0_d   = state_d == LOAD && !gnt_d;
        pop1_d   = state_d == LOAD && gnt_d;
        datain_d = (state_d == LOAD) ? (gnt_d ? bus.req1_data : bus.req0_data) : 8'd0;
        done_d   = state_d == DONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmd_q    <= 3'd0;
            datain_q <= 8'd0;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
            pop0_q   <= 1'b0;
            pop1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            datain_q <= datain_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            ready0_q <= ready0_d;
            ready1_q <= ready1_d;
            pop0_q   <= pop0_d;
            pop1_q   <= pop1_d;
        end
    end

    assign bus.lcd_cmd       = cmd_q;
    assign bus.lcd_cmd_valid = valid_q;
    assign bus.lcd_datain    = datain_q;
    assign bus.grant_id      = gnt_q;
    assign bus.done          = done_q;
    assign bus.req0_ready    = ready0_q;
    assign bus.req1_ready    = ready1_q;
    assign bus.req0_pop      = pop0_q;
    assign bus.req1_pop      = pop1_q;
endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// tb_lcd_cmd_arbiter: directed self-checking bench for lcd_cmd_arbiter
module tb_lcd_cmd_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    lcd_cmd_arbiter_if bus ();

    lcd_cmd_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {13'd0, bus.lcd_cmd, bus.lcd_cmd_valid, bus.lcd_datain, bus.req0_ready,
                bus.req1_ready, bus.req0_pop, bus.req1_pop, bus.grant_id, bus.done};
    endfunction

    task automatic wait_strobe(input int bound);
        int n = 0;
        while (!bus.lcd_cmd_valid && n < bound) begin
            tick;
            n++;
        end
        chk("strobe_timeout", {31'd0, bus.lcd_cmd_valid}, 32'd1);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!bus.done && n < bound) begin
            tick;
            n++;
        end
        chk("done_timeout", {31'd0, bus.done}, 32'd1);
        tick;
        chk("done_pulse", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        logic [31:0] g;
        reset = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_cmd = 3'd0; bus.req0_data = 8'd0;
        bus.req1_valid = 1'b0; bus.req1_cmd = 3'd0; bus.req1_data = 8'd0;
        bus.lcd_busy = 1'b0;
        repeat (3) tick;
        chk("reset_outs", outs(), 32'd0);
        reset = 1'b1;
        tick;

        // req0 cmd 3, busy held 5 cycles after the strobe
        bus.req0_valid = 1'b1; bus.req0_cmd = 3'd3;
        tick;
        chk("t1_valid", {31'd0, bus.lcd_cmd_valid}, 32'd1);
        chk("t1_cmd", {29'd0, bus.lcd_cmd}, 32'd3);
        chk("t1_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'b10);
        chk("t1_grant", {31'd0, bus.grant_id}, 32'd0);
        bus.req0_valid = 1'b0;
        bus.lcd_busy = 1'b1;
        repeat (5) begin
            tick;
            chk("t1_no_done", {31'd0, bus.done}, 32'd0);
            chk("t1_single_strobe", {31'd0, bus.lcd_cmd_valid}, 32'd0);
        end
        bus.lcd_busy = 1'b0;
        tick;
        chk("t1_done", {31'd0, bus.done}, 32'd1);
        chk("t1_cmd_hold", {29'd0, bus.lcd_cmd}, 32'd3);
        tick;
        chk("t1_done_once", {31'd0, bus.done}, 32'd0);

        // req1 load with 108-pixel ramp
        bus.req1_valid = 1'b1; bus.req1_cmd = 3'd0; bus.req1_data = 8'd0;
        tick;
        chk("t2_strobe", {28'd0, bus.lcd_cmd_valid, bus.lcd_cmd}, 32'b1000);
        chk("t2_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'b01);
        chk("t2_grant", {31'd0, bus.grant_id}, 32'd1);
        bus.req1_valid = 1'b0;
        for (int k = 0; k < 108; k++) begin
            tick;
            chk("t2_pop", {30'd0, bus.req0_pop, bus.req1_pop}, 32'b01);
            chk("t2_pixel", {24'd0, bus.lcd_datain}, k);
            bus.req1_data = 8'(k + 1);
        end
        tick;
        chk("t2_after_pop", {30'd0, bus.req0_pop, bus.req1_pop}, 32'd0);
        chk("t2_after_data", {24'd0, bus.lcd_datain}, 32'd0);
        bus.lcd_busy = 1'b1;
        repeat (3) begin
            tick;
            chk("t2_no_done", {31'd0, bus.done}, 32'd0);
        end
        bus.lcd_busy = 1'b0;
        tick;
        chk("t2_done", {31'd0, bus.done}, 32'd1);
        tick;

        // both valid continuously: arbitration order
        bus.req0_valid = 1'b1; bus.req0_cmd = 3'd1;
        bus.req1_valid = 1'b1; bus.req1_cmd = 3'd2;
        for (int i = 0; i < 4; i++) begin
            wait_strobe(20);
`ifdef LCD_ARB_FIXED_PRIO_EN
            g = 32'd0;
`else
            g = 32'(i % 2);
`endif
            chk("t3_grant", {31'd0, bus.grant_id}, g);
            chk("t3_ready", {30'd0, bus.req0_ready, bus.req1_ready}, g[0] ? 32'b01 : 32'b10);
            chk("t3_cmd", {29'd0, bus.lcd_cmd}, g[0] ? 32'd2 : 32'd1);
            if (i == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            tick;
        end
        wait_done(20);

        // busy never rises: done BUSY_TO cycles after WAIT_HI entry
        bus.req1_valid = 1'b1; bus.req1_cmd = 3'd5;
        tick;
        chk("t4_strobe", {28'd0, bus.lcd_cmd_valid, bus.lcd_cmd}, 32'b1101);
        bus.req1_valid = 1'b0;
        repeat (4) begin
            tick;
            chk("t4_wait", {31'd0, bus.done}, 32'd0);
        end
        tick;
        chk("t4_done", {31'd0, bus.done}, 32'd1);
        tick;
        chk("t4_done_once", {31'd0, bus.done}, 32'd0);

        // busy high before request holds off the grant
        bus.lcd_busy = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_cmd = 3'd2;
        repeat (5) begin
            tick;
            chk("t5_held", {29'd0, bus.lcd_cmd_valid, bus.req0_ready, bus.req1_ready}, 32'd0);
        end
        bus.lcd_busy = 1'b0;
        tick;
        chk("t5_strobe", {29'd0, bus.lcd_cmd_valid, bus.req0_ready, bus.req1_ready}, 32'b110);
        bus.req0_valid = 1'b0;
        wait_done(10);

        // reset mid-load, then req0 wins the tie
        bus.req1_valid = 1'b1; bus.req1_cmd = 3'd0; bus.req1_data = 8'd0;
        tick;
        chk("t6_grant", {31'd0, bus.grant_id}, 32'd1);
        bus.req1_valid = 1'b0;
        for (int k = 0; k <= 50; k++) begin
            tick;
            chk("t6_pixel", {24'd0, bus.lcd_datain}, k);
            bus.req1_data = 8'(k + 1);
        end
        reset = 1'b0;
        #1;
        chk("t6_async_reset", outs(), 32'd0);
        bus.req0_valid = 1'b1; bus.req0_cmd = 3'd4;
        bus.req1_valid = 1'b1; bus.req1_cmd = 3'd6;
        repeat (2) tick;
        chk("t6_in_reset", outs(), 32'd0);
        reset = 1'b1;
        tick;
        chk("t6_first_grant", {31'd0, bus.grant_id}, 32'd0);
        chk("t6_cmd", {28'd0, bus.lcd_cmd_valid, bus.lcd_cmd}, 32'b1100);
        chk("t6_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'b10);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_done(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
